operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Pipeline stage between decode and execute in the copperv CPU.
//  - Accepts a decoded instruction (valid/ready), drives the register_file read port, captures rs1/rs2 data.
//  - Forwards concurrent writeback data, presents operands + payload to execute (valid/ready).
//  - Also snoops the register_file write port (wb_*), which it does not drive.
// PARAMETERS
//  reg_width      5   register index width (32 architectural regs)
//  data_width     32  operand/data width
//  payload_width  32  opaque decode fields passed through (opcode, imm, rd, ...)
// PORTS
//  clk          in   1              clock, rising edge
//  rst          in   1              reset, asynchronous, active-low
//  in_valid     in   1              decoded instruction valid
//  in_ready     out  1              stage can accept an instruction
//  in_rs1       in   reg_width      source 1 index
//  in_rs2       in   reg_width      source 2 index
//  in_rs1_use   in   1              instruction reads rs1
//  in_rs2_use   in   1              instruction reads rs2
//  in_payload   in   payload_width  pass-through fields
//  rf_rs1_en    out  1              register_file rs1 read enable
//  rf_rs2_en    out  1              register_file rs2 read enable
//  rf_rs1       out  reg_width      register_file rs1 index
//  rf_rs2       out  reg_width      register_file rs2 index
//  rf_rs1_dout  in   data_width     register_file rs1 data (registered, 1-cycle)
//  rf_rs2_dout  in   data_width     register_file rs2 data (registered, 1-cycle)
//  wb_en        in   1              writeback enable (same net as register_file rd_en)
//  wb_rd        in   reg_width      writeback index
//  wb_din       in   data_width     writeback data
//  out_valid    out  1              operands valid to execute
//  out_ready    in   1              execute accepts
//  out_rs1_data out  data_width     operand 1
//  out_rs2_data out  data_width     operand 2
//  out_payload  out  payload_width  latched in_payload
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; out_valid=0; all rf_* and out_* outputs and latched fields = 0.
//  - States:
//    - IDLE: in_ready=1. in_valid → latch rs1/rs2/use/payload, go ISSUE.
//    - ISSUE: rf_rs1_en = use1|use2, rf_rs2_en = use2, rf_rs1/rf_rs2 = latched indices.
//      - register_file rule: a write (wb_en && wb_rd!=0) suppresses reads that cycle.
//      - register_file rule: rs2 is read only while rs1_en is also high.
//      - Write active this cycle → stay ISSUE (retry); else → CAPTURE.
//    - CAPTURE: register rf_*_dout into operand regs, then → VALID.
//    - VALID: out_valid=1; hold all outputs until out_ready.
//  - in_ready = IDLE | (VALID & out_ready).
//  - Handshake in VALID (out_valid & out_ready):
//    - in_valid=1 → latch new instruction, go ISSUE (back-to-back).
//    - else → IDLE.
//  - rf enables are 0 outside ISSUE.
//  - Latency: accept at cycle T → out_valid at T+3 with no retries; each retry adds 1 cycle.
//  - Forwarding, in CAPTURE and VALID states:
//    - Applies when wb_en && wb_rd==rsN && rsN!=0 && useN.
//    - The operand register takes wb_din instead of the rf/held value.
//    - Covers writes landing after the read sampled the array.
//    - Both operands may forward in the same cycle.
//  - Zero/unused operands:
//    - rsN==0 with useN → operand 0, never forwarded.
//    - !useN → operand 0.
//  - Output stability: out_* must not change while out_valid & !out_ready, except by forwarding.
//  - in_valid outside IDLE/VALID-handshake is ignored (in_ready=0); inputs are not sampled.
//  - Reset mid-operation: the in-flight instruction is dropped; no output pulse after reset release.
// STRUCTURE
//  - Shared header copperv_pkg (or the `include header): state encoding localparams
//    (IDLE/ISSUE/CAPTURE/VALID), default reg_width/data_width.
//  - Sub-module operand_forward (combinational): inputs rs, use, held/rf data, wb_*;
//    output selected operand. Instantiated twice.
//  - FSM, latches and handshake live in operand_fetch.
// TESTING
//  - Basic: x3=0x11, x4=0x22; issue rs1=3, rs2=4 → out_valid at T+3, out=0x11/0x22, payload intact.
//  - Write collision: wb_en, wb_rd=5 in ISSUE cycle → one retry; out_valid at T+4; rf_rs*_en held 2 cycles.
//  - Forward: x3=0x11, wb_rd=3, wb_din=0xAB during VALID with out_ready=0 → out_rs1_data becomes 0xAB.
//  - x0/unused: rs1=0 use1=1, use2=0; wb_rd=0 active → out_rs1_data=0, out_rs2_data=0, rf_rs2_en never 1.
//  - Backpressure/back-to-back:
//    - out_ready=0 for 5 cycles → outputs stable.
//    - Handshake with in_valid=1 → next instruction accepted same cycle; out_valid again 3 cycles later.
//  - Async reset in CAPTURE → all outputs 0 immediately; after release, no spurious out_valid.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared types and default widths for the copperv operand-fetch stage.
package operand_fetch_pkg;

  localparam int unsigned DefRegWidth     = 5;
  localparam int unsigned DefDataWidth    = 32;
  localparam int unsigned DefPayloadWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StValid
  } of_state_e;

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-side, register-file and execute-side signals of the operand-fetch stage.
interface operand_fetch_if
  import operand_fetch_pkg::*;
#(
  parameter int unsigned RegWidth     = DefRegWidth,
  parameter int unsigned DataWidth    = DefDataWidth,
  parameter int unsigned PayloadWidth = DefPayloadWidth
);

  logic                    in_valid;
  logic                    in_ready;
  logic [RegWidth-1:0]     in_rs1;
  logic [RegWidth-1:0]     in_rs2;
  logic                    in_rs1_use;
  logic                    in_rs2_use;
  logic [PayloadWidth-1:0] in_payload;

  logic                    rf_rs1_en;
  logic                    rf_rs2_en;
  logic [RegWidth-1:0]     rf_rs1;
  logic [RegWidth-1:0]     rf_rs2;
  logic [DataWidth-1:0]    rf_rs1_dout;
  logic [DataWidth-1:0]    rf_rs2_dout;

  logic                    wb_en;
  logic [RegWidth-1:0]     wb_rd;
  logic [DataWidth-1:0]    wb_din;

  logic                    out_valid;
  logic                    out_ready;
  logic [DataWidth-1:0]    out_rs1_data;
  logic [DataWidth-1:0]    out_rs2_data;
  logic [PayloadWidth-1:0] out_payload;

  // The stage's own view.
  modport master (
    input  in_valid, in_rs1, in_rs2, in_rs1_use, in_rs2_use, in_payload,
    output in_ready,
    output rf_rs1_en, rf_rs2_en, rf_rs1, rf_rs2,
    input  rf_rs1_dout, rf_rs2_dout,
    input  wb_en, wb_rd, wb_din,
    output out_valid, out_rs1_data, out_rs2_data, out_payload,
    input  out_ready
  );

  // The surrounding pipeline's view.
  modport slave (
    output in_valid, in_rs1, in_rs2, in_rs1_use, in_rs2_use, in_payload,
    input  in_ready,
    input  rf_rs1_en, rf_rs2_en, rf_rs1, rf_rs2,
    output rf_rs1_dout, rf_rs2_dout,
    output wb_en, wb_rd, wb_din,
    input  out_valid, out_rs1_data, out_rs2_data, out_payload,
    output out_ready
  );

endinterface

// File: rtl/operand_forward.sv
// Selects one operand: zero for x0/unused, writeback data on a matching write, else held data.
module operand_forward #(
  parameter int unsigned RegWidth  = 5,
  parameter int unsigned DataWidth = 32
) (
  input  logic [RegWidth-1:0]  rs,
  input  logic                 rs_use,
  input  logic [DataWidth-1:0] held,
  input  logic                 wb_en,
  input  logic [RegWidth-1:0]  wb_rd,
  input  logic [DataWidth-1:0] wb_din,
  output logic [DataWidth-1:0] operand
);

  always_comb begin
    operand = '0;
    if (rs_use && (rs != '0)) begin
      operand = (wb_en && (wb_rd == rs)) ? wb_din : held;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads the register file, forwards writeback data, hands
// operands and decode payload to execute over a valid/ready handshake.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned RegWidth     = DefRegWidth,
  parameter int unsigned DataWidth    = DefDataWidth,
  parameter int unsigned PayloadWidth = DefPayloadWidth
) (
  input  logic            clk,
  input  logic            rst,
  operand_fetch_if.master bus
);

  of_state_e               state_q;
  logic [RegWidth-1:0]     rs1_q, rs2_q;
  logic                    use1_q, use2_q;
  logic [PayloadWidth-1:0] payload_q;
  logic [DataWidth-1:0]    op1_q, op2_q;
  logic                    out_valid_q;

  logic                    wb_write;
  logic                    in_ready;
  logic                    accept;
  logic [DataWidth-1:0]    held1, held2;
  logic [DataWidth-1:0]    fwd1, fwd2;

  // A real write blocks the register file's read port for that cycle.
  assign wb_write = bus.wb_en && (bus.wb_rd != '0);
  assign in_ready = (state_q == StIdle) || ((state_q == StValid) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  assign held1 = (state_q == StCapture) ? bus.rf_rs1_dout : op1_q;
  assign held2 = (state_q == StCapture) ? bus.rf_rs2_dout : op2_q;

  operand_forward #(
    .RegWidth  (RegWidth),
    .DataWidth (DataWidth)
  ) u_fwd_rs1 (
    .rs      (rs1_q),
    .rs_use  (use1_q),
    .held    (held1),
    .wb_en   (bus.wb_en),
    .wb_rd   (bus.wb_rd),
    .wb_din  (bus.wb_din),
    .operand (fwd1)
  );

  operand_forward #(
    .RegWidth  (RegWidth),
    .DataWidth (DataWidth)
  ) u_fwd_rs2 (
    .rs      (rs2_q),
    .rs_use  (use2_q),
    .held    (held2),
    .wb_en   (bus.wb_en),
    .wb_rd   (bus.wb_rd),
    .wb_din  (bus.wb_din),
    .operand (fwd2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rs1_q       <= '0;
      rs2_q       <= '0;
      use1_q      <= 1'b0;
      use2_q      <= 1'b0;
      payload_q   <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        rs1_q     <= bus.in_rs1;
        rs2_q     <= bus.in_rs2;
        use1_q    <= bus.in_rs1_use;
        use2_q    <= bus.in_rs2_use;
        payload_q <= bus.in_payload;
      end
      unique case (state_q)
        StIdle: begin
          if (accept) state_q <= StIssue;
        end
        StIssue: begin
          if (!wb_write) state_q <= StCapture;
        end
        StCapture: begin
          op1_q       <= fwd1;
          op2_q       <= fwd2;
          out_valid_q <= 1'b1;
          state_q     <= StValid;
        end
        StValid: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= accept ? StIssue : StIdle;
          end else begin
            // Keep operands coherent with writebacks landing while stalled.
            op1_q <= fwd1;
            op2_q <= fwd2;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.rf_rs1_en    = (state_q == StIssue) && (use1_q || use2_q);
  assign bus.rf_rs2_en    = (state_q == StIssue) && use2_q;
  assign bus.rf_rs1       = rs1_q;
  assign bus.rf_rs2       = rs2_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_rs1_data = op1_q;
  assign bus.out_rs2_data = op2_q;
  assign bus.out_payload  = payload_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a small registered register-file model.
module tb_operand_fetch;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  operand_fetch_if bus ();

  operand_fetch u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Register file: 1-cycle registered reads, a write suppresses reads, rs2 needs rs1_en.
  logic [31:0] regs [32];
  logic [31:0] rf1, rf2;
  always @(posedge clk) begin
    if (bus.wb_en && bus.wb_rd != 5'd0) begin
      regs[bus.wb_rd] <= bus.wb_din;
    end else if (bus.rf_rs1_en) begin
      rf1 <= regs[bus.rf_rs1];
      if (bus.rf_rs2_en) rf2 <= regs[bus.rf_rs2];
    end
  end
  assign bus.rf_rs1_dout = rf1;
  assign bus.rf_rs2_dout = rf2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [31:0] payload);
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_rs1_use = u1;
    bus.in_rs2_use = u2;
    bus.in_payload = payload;
    bus.in_valid   = 1'b1;
    #1;
    check("acc_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_rs1     = '0;
    bus.in_rs2     = '0;
    bus.in_rs1_use = 1'b0;
    bus.in_rs2_use = 1'b0;
    bus.in_payload = '0;
    bus.wb_en      = 1'b0;
    bus.wb_rd      = '0;
    bus.wb_din     = '0;
    bus.out_ready  = 1'b0;
    rst            = 1'b0;
    #3;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_rf_en", {30'd0, bus.rf_rs1_en, bus.rf_rs2_en}, 32'd0);
    check("rst_rf_idx", {22'd0, bus.rf_rs1, bus.rf_rs2}, 32'd0);
    check("rst_out_data", bus.out_rs1_data | bus.out_rs2_data, 32'd0);
    check("rst_payload", bus.out_payload, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Preload x3=0x11, x4=0x22 through the writeback port.
    bus.wb_en = 1'b1; bus.wb_rd = 5'd3; bus.wb_din = 32'h11;
    tick();
    bus.wb_rd = 5'd4; bus.wb_din = 32'h22;
    tick();
    bus.wb_en = 1'b0;

    // Basic read, T+3 latency.
    accept(5'd3, 5'd4, 1'b1, 1'b1, 32'hDEADBEEF);
    check("basic_issue_en", {30'd0, bus.rf_rs1_en, bus.rf_rs2_en}, 32'd3);
    check("basic_issue_idx", {22'd0, bus.rf_rs1, bus.rf_rs2}, {22'd0, 5'd3, 5'd4});
    check("basic_busy_ready", {31'd0, bus.in_ready}, 32'd0);
    check("basic_t1_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check("basic_t2_valid", {31'd0, bus.out_valid}, 32'd0);
    check("basic_t2_en", {30'd0, bus.rf_rs1_en, bus.rf_rs2_en}, 32'd0);
    tick();
    check("basic_t3_valid", {31'd0, bus.out_valid}, 32'd1);
    check("basic_rs1", bus.out_rs1_data, 32'h11);
    check("basic_rs2", bus.out_rs2_data, 32'h22);
    check("basic_payload", bus.out_payload, 32'hDEADBEEF);
    handshake();
    check("basic_done_valid", {31'd0, bus.out_valid}, 32'd0);
    check("basic_done_ready", {31'd0, bus.in_ready}, 32'd1);

    // Write collision in ISSUE: one retry.
    accept(5'd4, 5'd3, 1'b1, 1'b1, 32'h1);
    bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_din = 32'h55;
    check("coll_en_c1", {30'd0, bus.rf_rs1_en, bus.rf_rs2_en}, 32'd3);
    tick();
    bus.wb_en = 1'b0;
    check("coll_en_c2", {30'd0, bus.rf_rs1_en, bus.rf_rs2_en}, 32'd3);
    check("coll_t2_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check("coll_t3_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check("coll_t4_valid", {31'd0, bus.out_valid}, 32'd1);
    check("coll_rs1", bus.out_rs1_data, 32'h22);
    check("coll_rs2", bus.out_rs2_data, 32'h11);

    // Backpressure: outputs hold.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_rs1", bus.out_rs1_data, 32'h22);
      check("bp_rs2", bus.out_rs2_data, 32'h11);
      check("bp_payload", bus.out_payload, 32'h1);
    end

    // Back-to-back: handshake and accept in the same cycle.
    bus.out_ready = 1'b1;
    accept(5'd3, 5'd4, 1'b1, 1'b1, 32'h2);
    bus.out_ready = 1'b0;
    check("b2b_issue_valid", {31'd0, bus.out_valid}, 32'd0);
    check("b2b_issue_en", {31'd0, bus.rf_rs1_en}, 32'd1);
    check("b2b_payload_new", bus.out_payload, 32'h2);
    tick();
    tick();
    check("b2b_t3_valid", {31'd0, bus.out_valid}, 32'd1);
    check("b2b_rs1", bus.out_rs1_data, 32'h11);

    // Forward during VALID while stalled.
    bus.wb_en = 1'b1; bus.wb_rd = 5'd3; bus.wb_din = 32'hAB;
    tick();
    bus.wb_en = 1'b0;
    check("fwd_valid_rs1", bus.out_rs1_data, 32'hAB);
    check("fwd_valid_rs2", bus.out_rs2_data, 32'h22);
    check("fwd_valid_hold", {31'd0, bus.out_valid}, 32'd1);
    handshake();

    // Forward in CAPTURE to both operands at once.
    accept(5'd4, 5'd4, 1'b1, 1'b1, 32'h3);
    tick();
    bus.wb_en = 1'b1; bus.wb_rd = 5'd4; bus.wb_din = 32'h77;
    tick();
    bus.wb_en = 1'b0;
    check("fwd_cap_valid", {31'd0, bus.out_valid}, 32'd1);
    check("fwd_cap_rs1", bus.out_rs1_data, 32'h77);
    check("fwd_cap_rs2", bus.out_rs2_data, 32'h77);
    handshake();

    // x0 source and unused rs2, with a writeback to x0 active throughout.
    accept(5'd0, 5'd4, 1'b1, 1'b0, 32'h4);
    bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_din = 32'h99;
    check("x0_issue_en", {30'd0, bus.rf_rs1_en, bus.rf_rs2_en}, 32'd2);
    tick();
    check("x0_no_retry_en", {30'd0, bus.rf_rs1_en, bus.rf_rs2_en}, 32'd0);
    tick();
    check("x0_valid", {31'd0, bus.out_valid}, 32'd1);
    check("x0_rs1", bus.out_rs1_data, 32'd0);
    check("x0_rs2", bus.out_rs2_data, 32'd0);
    bus.wb_en = 1'b0;
    handshake();

    // Asynchronous reset in CAPTURE.
    accept(5'd3, 5'd4, 1'b1, 1'b1, 32'h5);
    tick();
    #2 rst = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_rf_en", {30'd0, bus.rf_rs1_en, bus.rf_rs2_en}, 32'd0);
    check("arst_data", bus.out_rs1_data | bus.out_rs2_data, 32'd0);
    check("arst_payload", bus.out_payload, 32'd0);
    check("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("arst_no_pulse", {31'd0, bus.out_valid}, 32'd0);
    end

    // Stage still works after reset; x3=0xAB, x4=0x77 by now.
    accept(5'd3, 5'd4, 1'b1, 1'b1, 32'h6);
    tick();
    tick();
    check("post_valid", {31'd0, bus.out_valid}, 32'd1);
    check("post_rs1", bus.out_rs1_data, 32'hAB);
    check("post_rs2", bus.out_rs2_data, 32'h77);
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
